// File: rtl/division_secuencial_if.sv
// Operand/result bundle for the sequential divider.
// Master drives the request (start, Num1, Num2); slave returns registered results and status.
interface division_secuencial_if #(
  parameter int unsigned WIDTH = 4
);
  logic             start;
  logic [WIDTH-1:0] Num1;
  logic [WIDTH-1:0] Num2;
  logic [WIDTH-1:0] Cociente;
  logic [WIDTH-1:0] Residuo;
  logic             busy;
  logic             done;
  logic             div_cero;

  modport master (
    output start, Num1, Num2,
    input  Cociente, Residuo, busy, done, div_cero
  );

  modport slave (
    input  start, Num1, Num2,
    output Cociente, Residuo, busy, done, div_cero
  );
endinterface

// File: rtl/division_secuencial.sv
// Sequential restoring divider for unsigned operands, one quotient bit per clock.
// A zero divisor completes immediately with an all-ones quotient and the dividend as remainder.
// Optional macro DIV_EARLY_EXIT_EN: a dividend smaller than a nonzero divisor completes at the
// accepting edge instead of running the full step sequence; results are identical either way.
module division_secuencial #(
  parameter int unsigned WIDTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  division_secuencial_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] dvd_q;   // dividend shift register, MSB consumed each step
  logic [WIDTH-1:0] dvs_q;   // latched divisor
  logic [WIDTH-1:0] rem_q;   // partial remainder
  logic [WIDTH-1:0] quo_q;   // working quotient
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] cociente_q;
  logic [WIDTH-1:0] residuo_q;
  logic             busy_q;
  logic             done_q;
  logic             div_cero_q;

  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   diff;
  logic             take;
  logic [WIDTH-1:0] rem_nx;
  logic [WIDTH-1:0] quo_nx;

  // One restoring step: trial fits in WIDTH+1 bits since rem < divisor.
  always_comb begin
    trial  = {rem_q, dvd_q[WIDTH-1]};
    take   = (trial >= {1'b0, dvs_q});
    diff   = trial - {1'b0, dvs_q};
    rem_nx = take ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
    quo_nx = {quo_q[WIDTH-2:0], take};
  end

  // Control FSM with registered results and status.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      dvd_q      <= '0;
      dvs_q      <= '0;
      rem_q      <= '0;
      quo_q      <= '0;
      cnt_q      <= '0;
      cociente_q <= '0;
      residuo_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      div_cero_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.start) begin
            if (bus.Num2 == '0) begin
              state_q    <= StDone;
              busy_q     <= 1'b1;
              done_q     <= 1'b1;
              cociente_q <= '1;
              residuo_q  <= bus.Num1;
              div_cero_q <= 1'b1;
            end
`ifdef DIV_EARLY_EXIT_EN
            else if (bus.Num1 < bus.Num2) begin
              state_q    <= StDone;
              busy_q     <= 1'b1;
              done_q     <= 1'b1;
              cociente_q <= '0;
              residuo_q  <= bus.Num1;
              div_cero_q <= 1'b0;
            end
`endif
            else begin
              state_q <= StCalc;
              busy_q  <= 1'b1;
              dvd_q   <= bus.Num1;
              dvs_q   <= bus.Num2;
              rem_q   <= '0;
              quo_q   <= '0;
              cnt_q   <= CntW'(WIDTH);
            end
          end
        end
        StCalc: begin
          dvd_q <= dvd_q << 1;
          rem_q <= rem_nx;
          quo_q <= quo_nx;
          cnt_q <= cnt_q - CntW'(1);
          if (cnt_q == CntW'(1)) begin
            state_q    <= StDone;
            done_q     <= 1'b1;
            cociente_q <= quo_nx;
            residuo_q  <= rem_nx;
            div_cero_q <= 1'b0;
          end
        end
        StDone: begin
          state_q <= StIdle;
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.Cociente = cociente_q;
  assign bus.Residuo  = residuo_q;
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.div_cero = div_cero_q;

endmodule
